// File: rtl/shift_issue_stage.sv
// Shift issue stage: 2-entry request queue feeding left/right shifters into a result register.
// Latency: one edge from acceptance to out_valid (push at edge N, result after edge N+1).
// Backpressure: in_ready drops when two requests are queued; result and queue hold while out_valid && !out_ready.
//
// Ports: CLK/RESET (sync, active-high); in_valid/in_ready/in_left/in_data1/in_data2 request side;
//        out_valid/out_ready/out_result result side; occupancy = queued requests not yet executed.

// Small synchronous FIFO. DEPTH must be >= 2; head is read combinationally.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wr_dat,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_dat = mem_q[rd_ptr_q];
    assign count  = count_q;
endmodule

// Logical left shift; amounts of 8 or more clear the value.
module left_shift (
    input  logic [7:0] dat_i,
    input  logic [3:0] amt,
    output logic [7:0] dat_o
);
    assign dat_o = dat_i << amt;
endmodule

// Right-shift family: mode 00 logical, 01 arithmetic, 10 rotate (amount [2:0]), 11 reserved (drives 0).
module right_shift (
    input  logic [7:0] dat_i,
    input  logic [3:0] amt,
    input  logic [1:0] mode,
    output logic [7:0] dat_o
);
    logic [2:0] rot;
    assign rot = amt[2:0];

    always_comb begin
        case (mode)
            2'b00:   dat_o = dat_i >> amt;
            2'b01:   dat_o = $signed(dat_i) >>> amt;
            // rot == 0 makes the left term shift by 8, which is 0 in 8-bit context
            2'b10:   dat_o = (dat_i >> rot) | (dat_i << (4'd8 - {1'b0, rot}));
            default: dat_o = 8'h00;
        endcase
    end
endmodule

module shift_issue_stage (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_left,
    input  logic [7:0] in_data1,
    input  logic [7:0] in_data2,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
    output logic [1:0] occupancy
);
    typedef struct packed {
        logic       left;
        logic [7:0] d1;
        logic [7:0] d2;
    } req_t;

    req_t       wr_req;
    req_t       head;
    logic       push;
    logic       pop;
    logic [7:0] lsh_dat;
    logic [7:0] rsh_dat;
    logic       out_valid_q, out_valid_d;
    logic [7:0] result_q, result_d;
    logic       ctl_unused;

    assign wr_req = '{left: in_left, d1: in_data1, d2: in_data2};

    // No pass-through when full: a pop in the same cycle does not open a slot.
    assign in_ready = (occupancy < 2'd2) && !RESET;
    assign push     = in_valid && in_ready;
    assign pop      = (occupancy != 2'd0) && (!out_valid_q || out_ready);

    sync_fifo #(.W($bits(req_t)), .DEPTH(2)) u_fifo (
        .clk    (CLK),
        .rst    (RESET),
        .push   (push),
        .pop    (pop),
        .wr_dat (wr_req),
        .rd_dat (head),
        .count  (occupancy)
    );

    left_shift u_lsh (
        .dat_i (head.d1),
        .amt   (head.d2[3:0]),
        .dat_o (lsh_dat)
    );

    right_shift u_rsh (
        .dat_i (head.d1),
        .amt   (head.d2[3:0]),
        .mode  (head.d2[7:6]),
        .dat_o (rsh_dat)
    );

    // data2[5:4] carry no meaning but travel with the request.
    assign ctl_unused = ^head.d2[5:4];

    always_comb begin
        result_d    = result_q;
        out_valid_d = out_valid_q;
        if (pop) begin
            result_d    = head.left ? lsh_dat : rsh_dat;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            result_q    <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = result_q;
endmodule

// File: tb/tb_shift_issue_stage.sv
module tb_shift_issue_stage;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       in_valid;
    logic       in_ready;
    logic       in_left;
    logic [7:0] in_data1;
    logic [7:0] in_data2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [1:0] occupancy;

    int total = 0;
    int bad   = 0;

    shift_issue_stage dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_left    (in_left),
        .in_data1   (in_data1),
        .in_data2   (in_data2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .occupancy  (occupancy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       left;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic l, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_left  = l;
        in_data1 = a;
        in_data2 = b;
    endtask

    // Bit-serial reference shifter.
    function automatic logic [7:0] model(input logic l, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        int amt;
        r   = a;
        amt = int'(b[3:0]);
        if (l) begin
            for (int i = 0; i < amt; i++) r = {r[6:0], 1'b0};
        end else begin
            case (b[7:6])
                2'b00:   for (int i = 0; i < amt; i++) r = {1'b0, r[7:1]};
                2'b01:   for (int i = 0; i < amt; i++) r = {r[7], r[7:1]};
                2'b10:   for (int i = 0; i < int'(b[2:0]); i++) r = {r[0], r[7:1]};
                default: r = 8'hxx;
            endcase
        end
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] expq [$];
        logic [7:0] sd1, sd2;
        logic       sl;
        int sent, got, bubbles;
        logic seen;

        vecs[0]  = '{1'b1, 8'h35, 8'h02, 8'hD4};
        vecs[1]  = '{1'b0, 8'h80, 8'h03, 8'h10};
        vecs[2]  = '{1'b0, 8'h80, 8'h43, 8'hF0};
        vecs[3]  = '{1'b0, 8'h01, 8'h81, 8'h80};
        vecs[4]  = '{1'b1, 8'hFF, 8'h08, 8'h00};
        vecs[5]  = '{1'b0, 8'h9A, 8'h48, 8'hFF};
        vecs[6]  = '{1'b0, 8'h9A, 8'h08, 8'h00};
        vecs[7]  = '{1'b1, 8'h81, 8'h00, 8'h81};
        vecs[8]  = '{1'b0, 8'h0F, 8'h84, 8'hF0};
        vecs[9]  = '{1'b0, 8'hC3, 8'h82, 8'hF0};
        vecs[10] = '{1'b0, 8'h12, 8'h41, 8'h09};
        vecs[11] = '{1'b0, 8'h81, 8'h88, 8'h81};

        RESET = 1'b1; in_valid = 1'b0; in_left = 1'b0;
        in_data1 = 8'h00; in_data2 = 8'h00; out_ready = 1'b0;
        step; step;
        chk("rst_occ",   {6'b0, occupancy}, 8'd0);
        chk("rst_valid", {7'b0, out_valid}, 8'd0);
        chk("rst_res",   out_result,        8'h00);
        chk("rst_rdy",   {7'b0, in_ready},  8'd0);
        RESET = 1'b0;

        // Single requests into an empty stage; the first one lands on the first edge out of reset.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].left, vecs[i].d1, vecs[i].d2);
            out_ready = 1'b1;
            #1 chk($sformatf("v%0d_rdy", i), {7'b0, in_ready}, 8'd1);
            step;
            in_valid = 1'b0;
            chk($sformatf("v%0d_occ1", i), {6'b0, occupancy}, 8'd1);
            chk($sformatf("v%0d_nv", i),   {7'b0, out_valid}, 8'd0);
            step;
            chk($sformatf("v%0d_valid", i), {7'b0, out_valid}, 8'd1);
            chk($sformatf("v%0d_res", i),   out_result,        vecs[i].exp);
            chk($sformatf("v%0d_occ0", i),  {6'b0, occupancy}, 8'd0);
            step;
            chk($sformatf("v%0d_clr", i),  {7'b0, out_valid}, 8'd0);
        end

        // Right modes issued back to back.
        out_ready = 1'b1;
        drive(1'b0, 8'h80, 8'h03); step;
        chk("seq_occ", {6'b0, occupancy}, 8'd1);
        drive(1'b0, 8'h80, 8'h43); step;
        chk("seq_v0", {7'b0, out_valid}, 8'd1);
        chk("seq_r0", out_result, 8'h10);
        drive(1'b0, 8'h01, 8'h81); step;
        chk("seq_r1", out_result, 8'hF0);
        in_valid = 1'b0; step;
        chk("seq_r2", out_result, 8'h80);
        chk("seq_v2", {7'b0, out_valid}, 8'd1);
        step;
        chk("seq_end", {7'b0, out_valid}, 8'd0);

        // Backpressure: four offers, three fit.
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 8'h01);
        #1 chk("bp_rdy0", {7'b0, in_ready}, 8'd1);
        step;
        chk("bp_occ1", {6'b0, occupancy}, 8'd1);
        drive(1'b1, 8'h01, 8'h02); step;
        chk("bp_occ1b", {6'b0, occupancy}, 8'd1);
        chk("bp_resA",  out_result, 8'h02);
        drive(1'b1, 8'h01, 8'h03); step;
        chk("bp_occ2", {6'b0, occupancy}, 8'd2);
        drive(1'b1, 8'h01, 8'h04);
        #1 chk("bp_full", {7'b0, in_ready}, 8'd0);
        step;
        chk("bp_hold_occ", {6'b0, occupancy}, 8'd2);
        chk("bp_hold_res", out_result, 8'h02);
        chk("bp_hold_v",   {7'b0, out_valid}, 8'd1);
        out_ready = 1'b1;
        #1 chk("bp_nopass", {7'b0, in_ready}, 8'd0);
        step;
        chk("bp_resB", out_result, 8'h04);
        chk("bp_occB", {6'b0, occupancy}, 8'd1);
        #1 chk("bp_rdyD", {7'b0, in_ready}, 8'd1);
        step;
        in_valid = 1'b0;
        chk("bp_resC", out_result, 8'h08);
        chk("bp_occC", {6'b0, occupancy}, 8'd1);
        step;
        chk("bp_resD", out_result, 8'h10);
        chk("bp_occD", {6'b0, occupancy}, 8'd0);
        step;
        chk("bp_end", {7'b0, out_valid}, 8'd0);

        // Reset with a full queue and a pending result.
        out_ready = 1'b0;
        drive(1'b1, 8'h03, 8'h01); step;
        drive(1'b1, 8'h03, 8'h02); step;
        drive(1'b1, 8'h03, 8'h03); step;
        chk("mr_pre_occ", {6'b0, occupancy}, 8'd2);
        chk("mr_pre_v",   {7'b0, out_valid}, 8'd1);
        RESET = 1'b1; out_ready = 1'b1;
        drive(1'b1, 8'h55, 8'h01);
        #1 chk("mr_rdy_rst", {7'b0, in_ready}, 8'd0);
        step;
        RESET = 1'b0; in_valid = 1'b0;
        chk("mr_occ", {6'b0, occupancy}, 8'd0);
        chk("mr_v",   {7'b0, out_valid}, 8'd0);
        chk("mr_res", out_result, 8'h00);
        #1 chk("mr_rdy", {7'b0, in_ready}, 8'd1);
        step;
        chk("mr_after", {7'b0, out_valid}, 8'd0);

        // Streaming with random operands.
        sent = 0; got = 0; bubbles = 0; seen = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
            if (sent < 16) begin
                sl  = 1'($urandom_range(0, 1));
                sd1 = 8'($urandom);
                sd2 = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 8))};
                drive(sl, sd1, sd2);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid) begin
                chk("st_rdy", {7'b0, in_ready}, 8'd1);
                if (in_ready) begin
                    expq.push_back(model(sl, sd1, sd2));
                    sent++;
                end
            end
            step;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("st_extra", {7'b0, out_valid}, 8'd0);
                end else begin
                    chk($sformatf("st_res%0d", got), out_result, expq.pop_front());
                end
                got++;
                seen = 1'b1;
            end else if (seen) begin
                bubbles++;
            end
        end
        in_valid = 1'b0;
        chk("st_count",   8'(got),     8'd16);
        chk("st_bubbles", 8'(bubbles), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
